// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with writeback select and retire counter.
// Sub-word load formatting is built only when MEM_WB_LOAD_EXT_EN is defined.
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RegWriteIn,
  input  logic [1:0]  WBSelIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] MemDataIn,
  input  logic [31:0] PCPlus8In,
  input  logic [4:0]  WriteRegisterIn,
  input  logic [2:0]  LoadTypeIn,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        ValidOut,
  output logic [31:0] RetireCount
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  logic        r_valid;
  logic        r_regwrite_raw;
  logic [4:0]  r_write_register;
  logic [31:0] r_write_data;
  logic [31:0] r_retire_count;

  logic [31:0] w_load_value;
  logic [31:0] w_wb_data;
  logic        w_retire;

`ifdef MEM_WB_LOAD_EXT_EN
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic [7:0]  w_load_byte;
  logic [15:0] w_load_half;

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    w_load_byte = MemDataIn[31:24];
    case (ALUResultIn[1:0])
      2'd0:    w_load_byte = MemDataIn[31:24];
      2'd1:    w_load_byte = MemDataIn[23:16];
      2'd2:    w_load_byte = MemDataIn[15:8];
      default: w_load_byte = MemDataIn[7:0];
    endcase
    w_load_half = ALUResultIn[1] ? MemDataIn[15:0] : MemDataIn[31:16];
  end

  always_comb begin
    w_load_value = MemDataIn;
    case (LoadTypeIn)
      LT_LB:   w_load_value = {{24{w_load_byte[7]}}, w_load_byte};
      LT_LBU:  w_load_value = {24'd0, w_load_byte};
      LT_LH:   w_load_value = {{16{w_load_half[15]}}, w_load_half};
      LT_LHU:  w_load_value = {16'd0, w_load_half};
      default: w_load_value = MemDataIn;
    endcase
  end
`else
  logic [2:0] w_unused_load_type;

  assign w_unused_load_type = LoadTypeIn;
  assign w_load_value       = MemDataIn;
`endif

  always_comb begin
    w_wb_data = ALUResultIn;
    case (WBSelIn)
      WB_ALU:  w_wb_data = ALUResultIn;
      WB_MEM:  w_wb_data = w_load_value;
      WB_LINK: w_wb_data = PCPlus8In;
      default: w_wb_data = ALUResultIn;
    endcase
  end

  // Loads count as retiring even when they target no register.
  assign w_retire = RegWriteIn | (WBSelIn == WB_MEM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid          <= 1'b0;
      r_regwrite_raw   <= 1'b0;
      r_write_register <= 5'd0;
      r_write_data     <= 32'd0;
      r_retire_count   <= 32'd0;
    end else if (Flush) begin
      r_valid          <= 1'b0;
      r_regwrite_raw   <= 1'b0;
      r_write_register <= 5'd0;
      r_write_data     <= 32'd0;
    end else if (!Stall) begin
      r_valid          <= 1'b1;
      r_regwrite_raw   <= RegWriteIn;
      r_write_register <= WriteRegisterIn;
      r_write_data     <= w_wb_data;
      if (w_retire) begin
        r_retire_count <= r_retire_count + 32'd1;
      end
    end
  end

  assign WriteRegister = r_write_register;
  assign WriteData     = r_write_data;
  assign ValidOut      = r_valid;
  assign RetireCount   = r_retire_count;
  assign RegWrite      = r_regwrite_raw & r_valid & (r_write_register != 5'd0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with a behavioural model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, Stall, Flush, RegWriteIn;
  logic [1:0]  WBSelIn;
  logic [31:0] ALUResultIn, MemDataIn, PCPlus8In;
  logic [4:0]  WriteRegisterIn;
  logic [2:0]  LoadTypeIn;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite, ValidOut;
  logic [31:0] RetireCount;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .RegWriteIn(RegWriteIn), .WBSelIn(WBSelIn), .ALUResultIn(ALUResultIn),
    .MemDataIn(MemDataIn), .PCPlus8In(PCPlus8In), .WriteRegisterIn(WriteRegisterIn),
    .LoadTypeIn(LoadTypeIn), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite), .ValidOut(ValidOut), .RetireCount(RetireCount)
  );

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        rw;
    logic        v;
    logic [31:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Architectural view of the stage contents
  logic        m_valid = 0, m_rwraw = 0;
  logic [4:0]  m_wr = 0;
  logic [31:0] m_wd = 0, m_retire = 0;

  function automatic logic [31:0] load_fmt(logic [31:0] mem, logic [1:0] off, logic [2:0] lt);
    logic [31:0] b, h;
    b = (mem >> (8 * (3 - int'(off)))) & 32'hFF;
    h = (mem >> (off[1] ? 0 : 16)) & 32'hFFFF;
`ifdef MEM_WB_LOAD_EXT_EN
    case (lt)
      3'd1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return mem;
    endcase
`else
    return (lt == 3'd0 && b == h) ? mem : mem;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(bit rst, bit stl, bit fl, bit rw, logic [1:0] sel, logic [31:0] alu,
                       logic [31:0] mem, logic [31:0] pc8, logic [4:0] wr, logic [2:0] lt,
                       bit preload);
    exp_t e;
    @(negedge clk);
    if (preload) begin
      dut.r_retire_count = 32'hFFFF_FFFF;
      m_retire = 32'hFFFF_FFFF;
    end
    reset = rst; Stall = stl; Flush = fl; RegWriteIn = rw; WBSelIn = sel;
    ALUResultIn = alu; MemDataIn = mem; PCPlus8In = pc8; WriteRegisterIn = wr; LoadTypeIn = lt;
    if (rst) begin
      m_valid = 0; m_rwraw = 0; m_wr = 0; m_wd = 0; m_retire = 0;
    end else if (fl) begin
      m_valid = 0; m_rwraw = 0; m_wr = 0; m_wd = 0;
    end else if (!stl) begin
      m_valid = 1; m_rwraw = rw; m_wr = wr;
      m_wd = (sel == 2'b01) ? load_fmt(mem, alu[1:0], lt) : (sel == 2'b10) ? pc8 : alu;
      if (rw || sel == 2'b01) m_retire = m_retire + 1;
    end
    e.wr = m_wr; e.wd = m_wd; e.v = m_valid; e.rc = m_retire;
    e.rw = m_rwraw && m_valid && (m_wr != 0);
    exp_q.push_back(e);
  endtask

  task automatic rand_cycle(int p_rst, int p_fl, int p_stl);
    drive($urandom_range(0, 99) < p_rst, $urandom_range(0, 99) < p_stl,
          $urandom_range(0, 99) < p_fl, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("WriteRegister", 32'(WriteRegister), 32'(e.wr));
        check("WriteData", WriteData, e.wd);
        check("RegWrite", 32'(RegWrite), 32'(e.rw));
        check("ValidOut", 32'(ValidOut), 32'(e.v));
        check("RetireCount", RetireCount, e.rc);
      end
    end
  end

  initial begin : stimulus
    int guard;
    reset = 1; Stall = 0; Flush = 0; RegWriteIn = 0; WBSelIn = 0; ALUResultIn = 0;
    MemDataIn = 0; PCPlus8In = 0; WriteRegisterIn = 0; LoadTypeIn = 0;
    drive(1, 1, 1, 1, 2'b01, 32'h1, 32'h2, 32'h3, 5'd4, 3'd0, 0);
    drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 5'd0, 3'd0, 0);
    // ALU path, then LB/LBU from offset 1
    drive(0, 0, 0, 1, 2'b00, 32'h1234_5678, 0, 0, 5'd8, 3'd0, 0);
    drive(0, 0, 0, 1, 2'b01, 32'h0000_1001, 32'h11F0_2233, 0, 5'd9, 3'd1, 0);
    drive(0, 0, 0, 1, 2'b01, 32'h0000_1001, 32'h11F0_2233, 0, 5'd9, 3'd2, 0);
    for (int o = 0; o < 4; o++) begin
      drive(0, 0, 0, 1, 2'b01, 32'(o), 32'h8182_F384, 0, 5'd3, 3'd3, 0);
      drive(0, 0, 0, 0, 2'b01, 32'(o), 32'h8182_F384, 0, 5'd3, 3'd4, 0);
      drive(0, 0, 0, 1, 2'b01, 32'(o), 32'h8182_F384, 0, 5'd3, 3'd1, 0);
    end
    // Hold under stall, then flush wins over stall
    drive(0, 0, 0, 1, 2'b00, 32'hAAAA_5555, 0, 0, 5'd5, 3'd0, 0);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 1, 2'b01, $urandom, $urandom, $urandom, 5'd7, 3'd1, 0);
    drive(0, 1, 1, 1, 2'b00, 32'hDEAD_BEEF, 0, 0, 5'd6, 3'd0, 0);
    // Link write to $zero is suppressed
    drive(0, 0, 0, 1, 2'b10, 0, 0, 32'h0040_0008, 5'd0, 3'd0, 0);
    drive(0, 0, 0, 0, 2'b11, 32'hCAFE_0001, 0, 0, 5'd12, 3'd0, 0);
    // Counter wrap, then reset under stall mid-stream
    drive(0, 0, 0, 1, 2'b00, 32'h0000_0077, 0, 0, 5'd10, 3'd0, 1);
    drive(0, 0, 0, 1, 2'b00, 32'h0000_0078, 0, 0, 5'd11, 3'd0, 0);
    drive(1, 1, 0, 1, 2'b01, 32'h1, 32'h2, 0, 5'd13, 3'd1, 0);
    for (int i = 0; i < 400; i++) rand_cycle(2, 10, 20);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
